// File: rtl/conf_int_apx_pkg.sv
// Shared types and helpers for the configurable-precision adder controller.
package conf_int_apx_pkg;

  typedef enum logic [1:0] {
    MODE_FULL = 2'b00,
    MODE_APX  = 2'b01,
    MODE_OFF  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    SWITCH = 2'b10
  } state_e;

  // The unused encoding 2'b11 is treated as a request to power the adder off.
  function automatic mode_e mode_sanitize(input logic [1:0] m);
    return (m == 2'b11) ? MODE_OFF : mode_e'(m);
  endfunction

  // Adder domain resets {racc, rapx} for a mode. Without a distinct lower
  // domain (apx_en == 0) APX keeps both domains running, i.e. behaves as FULL.
  function automatic logic [1:0] mode_resets(input mode_e m, input logic apx_en);
    logic [1:0] r;
    case (m)
      MODE_FULL: r = 2'b11;
      MODE_APX:  r = apx_en ? 2'b10 : 2'b11;
      default:   r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/conf_int_res_fifo.sv
// Synchronous result FIFO; first-word-fall-through read, active-low sync reset.
module conf_int_res_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             racc,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign push_ok = push && (count != CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array holds data only and is never reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!racc) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conf_int_add_prec_ctrl.sv
// Initiator-side controller for the configurable-precision adder: issues
// operand pairs, sequences precision changes and buffers tagged results.
module conf_int_add_prec_ctrl
  import conf_int_apx_pkg::*;
#(
  parameter int OP_BITWIDTH        = 16,
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int ADD_LAT            = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          racc,
  input  logic [1:0]                    mode_req,
  output logic [1:0]                    mode_cur,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
  output logic [DATA_PATH_BITWIDTH-1:0] add_a,
  output logic [DATA_PATH_BITWIDTH-1:0] add_b,
  output logic                          add_racc,
  output logic                          add_rapx,
  input  logic [DATA_PATH_BITWIDTH-1:0] add_d,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] out_d,
  output logic                          out_apx
);

  localparam int   DW     = DATA_PATH_BITWIDTH;
  localparam logic APX_EN = (OP_BITWIDTH < DATA_PATH_BITWIDTH);
  localparam int   FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int   IFL_W  = $clog2(ADD_LAT + 2);
  localparam int   OCC_W  = $clog2(FIFO_DEPTH + ADD_LAT + 2);

  state_e            state;
  mode_e             target;
  mode_e             mode_q;
  mode_e             req;
  logic [ADD_LAT:0]  vld_p;
  logic [ADD_LAT:0]  apx_p;
  logic [IFL_W-1:0]  inflight;
  logic [FCNT_W-1:0] fifo_count;
  logic [OCC_W-1:0]  occ;
  logic              credit_ok;
  logic              issue;
  logic              fifo_empty;
  logic [DW:0]       fifo_rdata;

  assign req      = mode_sanitize(mode_req);
  assign mode_cur = mode_q;

  // Count of operations between issue and FIFO capture.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= ADD_LAT; i++) inflight = inflight + IFL_W'(vld_p[i]);
  end

  // Credit uses only registered occupancy, so a same-cycle pop frees nothing yet.
  assign occ       = OCC_W'(fifo_count) + OCC_W'(inflight);
  assign credit_ok = (occ < OCC_W'(FIFO_DEPTH));
  assign in_ready  = racc && (state == RUN) && (req == mode_q) &&
                     (mode_q != MODE_OFF) && credit_ok;
  assign issue     = in_valid && in_ready;

  // Mode sequencer: changes apply only once the adder pipe is empty, with a
  // single cycle of both domains held in reset to flush adder registers.
  always_ff @(posedge clk) begin
    if (!racc) begin
      state    <= SWITCH;
      target   <= MODE_FULL;
      mode_q   <= MODE_FULL;
      add_racc <= 1'b0;
      add_rapx <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (req != mode_q) begin
            target <= req;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == '0) begin
            add_racc <= 1'b0;
            add_rapx <= 1'b0;
            state    <= SWITCH;
          end
        end
        SWITCH: begin
          mode_q               <= target;
          {add_racc, add_rapx} <= mode_resets(target, APX_EN);
          state                <= RUN;
        end
        default: state <= SWITCH;
      endcase
    end
  end

  // ---- stage p0: operands registered toward the adder (zero when idle) ----
  always_ff @(posedge clk) begin
    if (!racc) begin
      add_a <= '0;
      add_b <= '0;
    end else begin
      add_a <= issue ? in_a : '0;
      add_b <= issue ? in_b : '0;
    end
  end

  // ---- stages p0..pADD_LAT: valid tag shift, aligned with adder latency ----
  always_ff @(posedge clk) begin
    if (!racc) vld_p <= '0;
    else       vld_p <= {vld_p[ADD_LAT-1:0], issue};
  end

  // Mode tag travels with the valid bit; its stale content is masked by vld_p.
  always_ff @(posedge clk) begin
    apx_p <= {apx_p[ADD_LAT-1:0], issue && (mode_q == MODE_APX)};
  end

  // ---- capture: adder result enters the FIFO when the tag reaches the end ----
  conf_int_res_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FCNT_W)
  ) u_fifo (
    .clk   (clk),
    .racc  (racc),
    .push  (vld_p[ADD_LAT]),
    .wdata ({apx_p[ADD_LAT], add_d}),
    .pop   (out_valid && out_ready),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_apx   = fifo_rdata[DW];
  assign out_d     = fifo_rdata[DW-1:0];

endmodule

// File: tb/tb_conf_int_add_prec_ctrl.sv
// Scoreboard bench for conf_int_add_prec_ctrl with a behavioural adder stand-in.
module tb_conf_int_add_prec_ctrl;
  import conf_int_apx_pkg::*;

  localparam int OPW = 8;
  localparam int DW  = 16;
  localparam int LW  = DW - OPW;
  localparam int LAT = 2;
  localparam int FD  = 4;

  logic          clk = 1'b0;
  logic          racc = 1'b0;
  logic [1:0]    mode_req = MODE_FULL;
  logic [1:0]    mode_cur;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [DW-1:0] add_a, add_b, add_d;
  logic          add_racc, add_rapx;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_d;
  logic          out_apx;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          apx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   accepts = 0;

  always #5 clk = ~clk;

  conf_int_add_prec_ctrl #(
    .OP_BITWIDTH(OPW), .DATA_PATH_BITWIDTH(DW), .ADD_LAT(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .racc(racc), .mode_req(mode_req), .mode_cur(mode_cur),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_racc(add_racc), .add_rapx(add_rapx),
    .add_d(add_d), .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_apx(out_apx)
  );

  // Adder stand-in: LAT register stages, each domain cleared by its reset.
  logic [DW-1:0] adp [LAT];

  function automatic logic [DW-1:0] adder_first(input logic [DW-1:0] a, b,
                                                input logic r_acc, r_apx);
    logic [LW:0]    lo;
    logic [OPW-1:0] hi;
    lo = r_apx ? ({1'b0, a[LW-1:0]} + {1'b0, b[LW-1:0]}) : '0;
    hi = r_acc ? (a[DW-1:LW] + b[DW-1:LW] + OPW'(lo[LW])) : '0;
    return {hi, lo[LW-1:0]};
  endfunction

  always @(posedge clk) begin
    adp[0] <= adder_first(add_a, add_b, add_racc, add_rapx);
    for (int i = 1; i < LAT; i++)
      adp[i] <= {add_racc ? adp[i-1][DW-1:LW] : {OPW{1'b0}},
                 add_rapx ? adp[i-1][LW-1:0]  : {LW{1'b0}}};
  end
  assign add_d = adp[LAT-1];

  // Reference: result of an accepted pair under the mode it was issued in.
  function automatic exp_t ref_add(input logic [DW-1:0] a, b, input logic [1:0] m);
    exp_t        e;
    int unsigned s;
    if (m == MODE_APX) begin
      s     = ((32'(a) >> LW) + (32'(b) >> LW)) % (32'd1 << OPW);
      e.d   = DW'(s << LW);
      e.apx = 1'b1;
    end else begin
      s     = (32'(a) + 32'(b)) % (32'd1 << DW);
      e.d   = DW'(s);
      e.apx = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Issue side of the scoreboard.
  always @(negedge clk) begin
    if (racc && in_valid && in_ready) begin
      sb.push_back(ref_add(in_a, in_b, mode_req));
      accepts++;
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (racc && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out actual=%0h required=none", out_d);
      end else begin
        mon_e = sb.pop_front();
        check("out_d", 32'(out_d), 32'(mon_e.d));
        check("out_apx", 32'(out_apx), 32'(mon_e.apx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin cyc(); n++; end
    repeat (6) cyc();
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin cyc(); @(negedge clk); n++; end
    check(name, 32'(in_ready), 32'd1);
    cyc();
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? 16'h0001 : 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic issue_rand();
    in_valid = 1'b1;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    cyc();
  endtask

  int lat, zc, n, a0;
  logic ok;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_add_racc", 32'(add_racc), 32'd0);
    check("rst_add_rapx", 32'(add_rapx), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_mode_cur", 32'(mode_cur), 32'(MODE_FULL));
    cyc();
    racc = 1'b1;
    @(negedge clk);
    check("switch_in_ready", 32'(in_ready), 32'd0);
    cyc();
    @(negedge clk);
    check("run_in_ready", 32'(in_ready), 32'd1);
    check("full_add_racc", 32'(add_racc), 32'd1);
    check("full_add_rapx", 32'(add_rapx), 32'd1);

    // Directed FULL op and latency
    cyc();
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0101;
    @(negedge clk);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
      cyc();
    end
    check("t1_latency", 32'(lat), 32'(LAT + 2));
    cyc();
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001;
    cyc();
    drain("t1_drain");

    rand_phase(200);
    drain("rand_full_drain");

    // Back-pressure: exactly FD accepted, then order preserved on release
    out_ready = 1'b0;
    a0 = accepts;
    for (int i = 0; i < 20; i++) issue_rand();
    @(negedge clk);
    check("t3_accepts", 32'(accepts - a0), 32'(FD));
    check("t3_in_ready", 32'(in_ready), 32'd0);
    cyc();
    drain("t3_drain");

    // FULL -> APX with two ops in flight
    out_ready = 1'b1;
    issue_rand();
    issue_rand();
    mode_req = MODE_APX;
    in_a = 16'($urandom); in_b = 16'($urandom);
    @(negedge clk);
    check("t4_in_ready_drop", 32'(in_ready), 32'd0);
    zc = 0; ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      if (!add_racc && !add_rapx) zc++;
    end
    check("t4_ready_back", 32'(ok), 32'd1);
    check("t4_switch_cycles", 32'(zc), 32'd1);
    check("t4_mode_cur", 32'(mode_cur), 32'(MODE_APX));
    cyc();
    drain("t4_drain");

    // Directed APX op, resets steady
    in_valid = 1'b1; in_a = 16'h12FF; in_b = 16'h0001;
    @(negedge clk);
    check("t2_in_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_add_racc", 32'(add_racc), 32'd1);
      check("t2_add_rapx", 32'(add_rapx), 32'd0);
      cyc();
    end
    drain("t2_drain");
    rand_phase(150);
    drain("rand_apx_drain");

    // Reset mid-operation
    mode_req = MODE_FULL;
    wait_ready("t5_pre_ready");
    out_ready = 1'b0;
    issue_rand();
    issue_rand();
    in_valid = 1'b0;
    repeat (6) cyc();
    issue_rand();
    issue_rand();
    in_valid = 1'b0;
    racc = 1'b0;
    sb.delete();
    cyc();
    racc = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'h0A0A; in_b = 16'h0505;
    @(negedge clk);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_add_racc", 32'(add_racc), 32'd0);
    check("t5_add_rapx", 32'(add_rapx), 32'd0);
    check("t5_switch_ready", 32'(in_ready), 32'd0);
    check("t5_mode_cur", 32'(mode_cur), 32'(MODE_FULL));
    cyc();
    @(negedge clk);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    cyc();
    drain("t5_drain");

    // OFF mode: no issue, buffered results still drain
    out_ready = 1'b0;
    issue_rand();
    issue_rand();
    in_valid = 1'b0;
    repeat (6) cyc();
    a0 = accepts;
    mode_req = MODE_OFF;
    in_valid = 1'b1;
    @(negedge clk);
    check("t6_in_ready_drop", 32'(in_ready), 32'd0);
    n = 0;
    while (mode_cur != MODE_OFF && n < 20) begin cyc(); @(negedge clk); n++; end
    check("t6_mode_off", 32'(mode_cur), 32'(MODE_OFF));
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      check("t6_in_ready", 32'(in_ready), 32'd0);
      check("t6_add_racc", 32'(add_racc), 32'd0);
      check("t6_add_rapx", 32'(add_rapx), 32'd0);
    end
    check("t6_no_accepts", 32'(accepts - a0), 32'd0);
    cyc();
    drain("t6_drain");
    mode_req = MODE_FULL;
    in_valid = 1'b1; in_a = 16'h00FF; in_b = 16'h0001;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      cyc();
    end
    check("t6_resume_cycles", 32'(n), 32'd3);
    cyc();
    drain("t6_final_drain");

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
